// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture slice: controller state encoding,
// RGB565 pixel width and the frame geometry produced by the on-chip mock
// camera (used as the controller's default geometry).
// -----------------------------------------------------------------------------
package cam_pkg;

  // One RGB565 pixel is two camera bytes.
  localparam int unsigned PIX_W = 16;

  // Geometry of the on-chip mock source.
  localparam int unsigned MOCK_FRAME_WIDTH  = 8;
  localparam int unsigned MOCK_FRAME_HEIGHT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_ERROR    = 2'd3
  } cam_state_e;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl_if
// Pixel stream from the capture controller to the AXI-Stream packer.
//   m_tdata  : pixel {first byte, second byte}
//   m_tvalid : pixel valid (held until accepted)
//   m_tready : downstream ready
//   m_tuser  : first pixel of a frame
//   m_tlast  : last pixel of a line
// master = capture controller, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface cam_capture_ctrl_if;

  logic [cam_pkg::PIX_W-1:0] m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tuser;
  logic                      m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tuser,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tuser,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/cam_sync_sampler.sv
// -----------------------------------------------------------------------------
// cam_sync_sampler
// Registers the camera pins once in the xclk domain, detects the pclk rising
// edge (a "sample event") and produces registered strobes aligned with the
// byte/HREF values captured at that event.
//   xclk, reset_n          : system clock, synchronous active-low reset
//   cam_pclk/vsync/href/data: raw camera signals (synchronous to xclk)
//   sample                 : one-cycle strobe, a pclk 0->1 was seen
//   href, data             : HREF and byte captured at that sample event
//   vsync_rise/vsync_fall  : VSYNC edge seen between consecutive sample events
//   href_fall              : HREF 1->0 seen between consecutive sample events
// -----------------------------------------------------------------------------
module cam_sync_sampler (
  input  logic       xclk,
  input  logic       reset_n,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       sample,
  output logic       href,
  output logic [7:0] data,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  logic       pclk_r;
  logic       pclk_d;
  logic       vsync_r;
  logic       href_r;
  logic [7:0] data_r;
  logic       vsync_last;
  logic       href_last;
  logic       ev;

  always_comb begin
    ev = pclk_r & ~pclk_d;
  end

  always_ff @(posedge xclk) begin
    if (!reset_n) begin
      pclk_r     <= 1'b0;
      pclk_d     <= 1'b0;
      vsync_r    <= 1'b0;
      href_r     <= 1'b0;
      data_r     <= '0;
      vsync_last <= 1'b0;
      href_last  <= 1'b0;
      sample     <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      vsync_rise <= 1'b0;
      vsync_fall <= 1'b0;
      href_fall  <= 1'b0;
    end else begin
      pclk_r  <= cam_pclk;
      vsync_r <= cam_vsync;
      href_r  <= cam_href;
      data_r  <= cam_data;
      pclk_d  <= pclk_r;

      sample     <= ev;
      href       <= href_r;
      data       <= data_r;
      vsync_rise <= ev &  vsync_r & ~vsync_last;
      vsync_fall <= ev & ~vsync_r &  vsync_last;
      href_fall  <= ev & ~href_r  &  href_last;

      // Edge history only advances on sample events, so edges are judged
      // in the camera's own timebase.
      if (ev) begin
        vsync_last <= vsync_r;
        href_last  <= href_r;
      end
    end
  end

endmodule

// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
// Sequences one OV7670-compatible camera source: enables it, locks onto the
// VSYNC falling edge, pairs RGB565 bytes into 16-bit pixels, checks line and
// frame geometry and streams pixels over a single-register valid/ready output.
//   xclk, reset_n   : system clock, synchronous active-low reset
//   start, abort    : command pulses (start only in IDLE, abort from anywhere)
//   num_frames      : frames to capture, latched on start (0 means 1)
//   cam_*           : camera pins / mock source, cam_enable drives its enable
//   m_axis          : pixel stream (master modport)
//   busy, done      : state != IDLE, one-cycle completion pulse
//   frames_done     : frames completed in the current run
//   err_*           : sticky error flags, cleared by an accepted start
// -----------------------------------------------------------------------------
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH   = MOCK_FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT  = MOCK_FRAME_HEIGHT,
  parameter int unsigned VSYNC_TIMEOUT = 65535,
  parameter int unsigned FCNT_W        = 8
) (
  input  logic              xclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FCNT_W-1:0] num_frames,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              cam_enable,
  cam_capture_ctrl_if.master m_axis,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frames_done,
  output logic              err_line_len,
  output logic              err_line_cnt,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int unsigned LINE_BYTES = 2 * FRAME_WIDTH;
  // Byte/line counters saturate one step above the legal value so that an
  // over-long line or frame is still distinguishable from a correct one.
  localparam int unsigned BCNT_W = $clog2(LINE_BYTES + 2);
  localparam int unsigned LCNT_W = $clog2(FRAME_HEIGHT + 2);
  localparam int unsigned TCNT_W = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;

  localparam logic [BCNT_W-1:0] LINE_BYTES_C = BCNT_W'(LINE_BYTES);
  localparam logic [BCNT_W-1:0] LAST_ODD_C   = BCNT_W'(LINE_BYTES - 1);
  localparam logic [BCNT_W-1:0] FIRST_ODD_C  = BCNT_W'(1);
  localparam logic [LCNT_W-1:0] LINES_C      = LCNT_W'(FRAME_HEIGHT);
  localparam logic [TCNT_W-1:0] TMO_LAST_C   = TCNT_W'(VSYNC_TIMEOUT - 1);

  cam_state_e        state;
  cam_state_e        state_n;

  logic              s_sample;
  logic              s_href;
  logic [7:0]        s_data;
  logic              s_vsync_rise;
  logic              s_vsync_fall;
  logic              s_href_fall;

  logic [BCNT_W-1:0] byte_cnt;
  logic [LCNT_W-1:0] line_cnt;
  logic [TCNT_W-1:0] tmo_cnt;
  logic [7:0]        byte_hi;
  logic [FCNT_W-1:0] frames_tgt;
  logic [FCNT_W-1:0] frames_inc;

  logic              accept_start;
  logic              enter_active;
  logic              timeout_hit;
  logic              frame_end;
  logic              run_done;
  logic              pix_ok;
  logic              pix_load;
  logic              pix_drop;
  logic              xfer;

  cam_sync_sampler u_sampler (
    .xclk       (xclk),
    .reset_n    (reset_n),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .sample     (s_sample),
    .href       (s_href),
    .data       (s_data),
    .vsync_rise (s_vsync_rise),
    .vsync_fall (s_vsync_fall),
    .href_fall  (s_href_fall)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge xclk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    accept_start = 1'b0;
    enter_active = 1'b0;
    timeout_hit  = 1'b0;
    frame_end    = 1'b0;
    run_done     = 1'b0;
    frames_inc   = frames_done + 1'b1;

    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            accept_start = 1'b1;
            state_n      = ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          // A rising edge here just means a frame is already under way;
          // only its falling edge marks a clean start of frame.
          if (s_vsync_fall) begin
            enter_active = 1'b1;
            state_n      = ST_ACTIVE;
          end else if (tmo_cnt == TMO_LAST_C) begin
            timeout_hit = 1'b1;
            state_n     = ST_ERROR;
          end
        end
        ST_ACTIVE: begin
          if (s_vsync_rise) begin
            frame_end = 1'b1;
            if (frames_inc == frames_tgt) begin
              run_done = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              state_n  = ST_WAIT_SOF;
            end
          end
        end
        ST_ERROR: begin
          state_n = ST_ERROR;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel completion and output-register handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    xfer     = m_axis.m_tvalid & m_axis.m_tready;
    pix_ok   = (state == ST_ACTIVE) && !abort && s_sample && s_href &&
               byte_cnt[0] && (byte_cnt < LINE_BYTES_C);
    // A transfer in the same cycle frees the register, so no drop then.
    pix_load = pix_ok && (!m_axis.m_tvalid || m_axis.m_tready);
    pix_drop = pix_ok && m_axis.m_tvalid && !m_axis.m_tready;
    busy     = (state != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath, counters and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge xclk) begin
    if (!reset_n) begin
      cam_enable      <= 1'b0;
      done            <= 1'b0;
      frames_done     <= '0;
      frames_tgt      <= '0;
      err_line_len    <= 1'b0;
      err_line_cnt    <= 1'b0;
      err_overflow    <= 1'b0;
      err_timeout     <= 1'b0;
      byte_cnt        <= '0;
      line_cnt        <= '0;
      tmo_cnt         <= '0;
      byte_hi         <= '0;
      m_axis.m_tdata  <= '0;
      m_axis.m_tvalid <= 1'b0;
      m_axis.m_tuser  <= 1'b0;
      m_axis.m_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (abort) begin
        cam_enable      <= 1'b0;
        m_axis.m_tvalid <= 1'b0;
      end else begin
        if (accept_start) begin
          err_line_len <= 1'b0;
          err_line_cnt <= 1'b0;
          err_overflow <= 1'b0;
          err_timeout  <= 1'b0;
          frames_done  <= '0;
          frames_tgt   <= (num_frames == '0) ? FCNT_W'(1) : num_frames;
          cam_enable   <= 1'b1;
          tmo_cnt      <= '0;
        end

        if (state == ST_WAIT_SOF) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end

        if (timeout_hit) begin
          err_timeout <= 1'b1;
          cam_enable  <= 1'b0;
        end

        if (enter_active) begin
          byte_cnt <= '0;
          line_cnt <= '0;
        end

        if ((state == ST_ACTIVE) && s_sample) begin
          if (s_href) begin
            if (!byte_cnt[0]) begin
              byte_hi <= s_data;
            end
            if (byte_cnt != '1) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (s_href_fall) begin
            if (byte_cnt != LINE_BYTES_C) begin
              err_line_len <= 1'b1;
            end
            if (line_cnt != '1) begin
              line_cnt <= line_cnt + 1'b1;
            end
            byte_cnt <= '0;
          end
        end

        if (frame_end) begin
          if (line_cnt != LINES_C) begin
            err_line_cnt <= 1'b1;
          end
          frames_done <= frames_inc;
          tmo_cnt     <= '0;
          if (run_done) begin
            done       <= 1'b1;
            cam_enable <= 1'b0;
          end
        end

        if (pix_drop) begin
          err_overflow <= 1'b1;
        end

        if (pix_load) begin
          m_axis.m_tvalid <= 1'b1;
          m_axis.m_tdata  <= {byte_hi, s_data};
          m_axis.m_tuser  <= (line_cnt == '0) && (byte_cnt == FIRST_ODD_C);
          m_axis.m_tlast  <= (byte_cnt == LAST_ODD_C);
        end else if (xfer) begin
          m_axis.m_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ctrl
// Drives a behavioural camera (frames of {row,col}^seed pixels) into the
// controller, predicts the delivered pixel stream into a scoreboard queue and
// compares it against the stream from a separate monitor process.  A second
// instance with a short VSYNC timeout and VSYNC tied low covers the timeout.
// -----------------------------------------------------------------------------
module tb_cam_capture_ctrl;

  localparam int unsigned CTRL_FW = 8;
  localparam int unsigned CTRL_FH = 4;

  logic       xclk = 1'b0;
  logic       reset_n;
  logic       start, abort;
  logic [7:0] num_frames;
  logic       cam_pclk, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic       cam_enable, busy, done;
  logic [7:0] frames_done;
  logic       err_line_len, err_line_cnt, err_overflow, err_timeout;
  logic [3:0] errs;

  logic       tmo_start, tmo_abort;
  logic       tmo_enable, tmo_busy, tmo_done;
  logic [7:0] tmo_frames_done;
  logic       tmo_err_line_len, tmo_err_line_cnt, tmo_err_overflow, tmo_err_timeout;

  cam_capture_ctrl_if axis_if ();
  cam_capture_ctrl_if tmo_if ();

  assign errs = {err_line_len, err_line_cnt, err_overflow, err_timeout};

  always #5 xclk = ~xclk;

  cam_capture_ctrl #(
    .FRAME_WIDTH   (CTRL_FW),
    .FRAME_HEIGHT  (CTRL_FH),
    .VSYNC_TIMEOUT (65535),
    .FCNT_W        (8)
  ) u_dut (
    .xclk         (xclk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .num_frames   (num_frames),
    .cam_pclk     (cam_pclk),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
    .cam_enable   (cam_enable),
    .m_axis       (axis_if),
    .busy         (busy),
    .done         (done),
    .frames_done  (frames_done),
    .err_line_len (err_line_len),
    .err_line_cnt (err_line_cnt),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  cam_capture_ctrl #(
    .FRAME_WIDTH   (CTRL_FW),
    .FRAME_HEIGHT  (CTRL_FH),
    .VSYNC_TIMEOUT (100),
    .FCNT_W        (8)
  ) u_dut_tmo (
    .xclk         (xclk),
    .reset_n      (reset_n),
    .start        (tmo_start),
    .abort        (tmo_abort),
    .num_frames   (8'd1),
    .cam_pclk     (1'b0),
    .cam_vsync    (1'b0),
    .cam_href     (1'b0),
    .cam_data     (8'h00),
    .cam_enable   (tmo_enable),
    .m_axis       (tmo_if),
    .busy         (tmo_busy),
    .done         (tmo_done),
    .frames_done  (tmo_frames_done),
    .err_line_len (tmo_err_line_len),
    .err_line_cnt (tmo_err_line_cnt),
    .err_overflow (tmo_err_overflow),
    .err_timeout  (tmo_err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int px_seen = 0;
  int tuser_seen = 0;
  int done_cnt = 0;
  int ready_mode = 2;   // 0 random (max 2 low in a row), 1 held low, 2 held high
  logic [17:0] sb[$];   // {tdata, tuser, tlast}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready.  A low run of at most two cycles guarantees the held
  // pixel leaves before the next one can arrive (pixels are >= 4 xclk apart).
  initial begin
    int low_run;
    low_run = 0;
    axis_if.m_tready = 1'b0;
    tmo_if.m_tready  = 1'b1;
    forever begin
      @(posedge xclk);
      #1;
      case (ready_mode)
        1: axis_if.m_tready = 1'b0;
        2: axis_if.m_tready = 1'b1;
        default: begin
          if (low_run >= 2 || $urandom_range(0, 2) != 0) begin
            axis_if.m_tready = 1'b1;
            low_run = 0;
          end else begin
            axis_if.m_tready = 1'b0;
            low_run++;
          end
        end
      endcase
    end
  end

  // Monitor: every accepted pixel is popped from the scoreboard and compared.
  always @(negedge xclk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (axis_if.m_tvalid && axis_if.m_tready) begin
        px_seen++;
        if (axis_if.m_tuser) tuser_seen++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel", axis_if.m_tdata);
        end else begin
          check("pixel", {axis_if.m_tdata, axis_if.m_tuser, axis_if.m_tlast}, sb.pop_front());
        end
      end
    end
  end

  // One camera byte slot: pclk low >= 1 cycle, then high >= 1 cycle.
  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge xclk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    cam_pclk  = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge xclk);
    cam_pclk = 1'b1;
    repeat ($urandom_range(0, 1)) @(negedge xclk);
  endtask

  task automatic pulse_start();
    @(negedge xclk) start = 1'b1;
    @(negedge xclk) start = 1'b0;
  endtask

  // mode: 0 no capture expected, 1 every pixel expected, 2 only the first.
  task automatic send_frame(input int w, input int h, input int mode, input logic [15:0] seed,
                            input int start_row, input int len_err_row0);
    logic [15:0] px;
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < h; r++) begin
      if (r == start_row) pulse_start();
      for (int c = 0; c < w; c++) begin
        px = {r[7:0], c[7:0]} ^ seed;
        tick(1'b0, 1'b1, px[15:8]);
        if (mode == 1 || (mode == 2 && r == 0 && c == 0))
          sb.push_back({px, (r == 0 && c == 0), (c == CTRL_FW - 1)});
        tick(1'b0, 1'b1, px[7:0]);
      end
      repeat (2) tick(1'b0, 1'b0, 8'h00);
      if (r == 0 && len_err_row0 >= 0) begin
        repeat (3) @(negedge xclk);
        check("line_len_after_row0", err_line_len, len_err_row0[0]);
      end
    end
  endtask

  task automatic vsync_close();
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge xclk);
    end
    repeat (2) @(negedge xclk);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, u0;
    logic [15:0] seed;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    tmo_start = 1'b0; tmo_abort = 1'b0;
    repeat (4) @(negedge xclk);
    check("reset_outputs", {axis_if.m_tvalid, cam_enable, busy, done, frames_done, errs}, 0);
    check("reset_tmo_outputs", {tmo_if.m_tvalid, tmo_enable, tmo_busy, tmo_done, tmo_frames_done}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge xclk);

    // Two frames, ready always high, seed 0 gives tdata {row,col}.
    num_frames = 8'd2; ready_mode = 2;
    d0 = done_cnt; p0 = px_seen; u0 = tuser_seen;
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_enable", cam_enable, 1);
    send_frame(8, 4, 1, 16'h0000, -1, -1);
    send_frame(8, 4, 1, 16'h0000, -1, -1);
    vsync_close();
    drain();
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_frames_done", frames_done, 2);
    check("t1_errors", errs, 0);
    check("t1_pixels", px_seen - p0, 64);
    check("t1_tuser", tuser_seen - u0, 2);
    check("t1_idle", {busy, cam_enable}, 0);
    // Frames arriving while idle must not be captured.
    send_frame(8, 4, 0, 16'h1234, -1, -1);
    vsync_close();
    drain();
    check("t1_idle_no_pixels", px_seen - p0, 64);

    // num_frames = 0 behaves as 1, random backpressure.
    num_frames = 8'd0; ready_mode = 0; d0 = done_cnt;
    pulse_start();
    seed = 16'($urandom_range(0, 65535));
    send_frame(8, 4, 1, seed, -1, -1);
    vsync_close();
    drain();
    check("t1b_frames_done", frames_done, 1);
    check("t1b_done_pulses", done_cnt - d0, 1);
    check("t1b_errors", errs, 0);

    // Start in the middle of a frame: that frame is skipped entirely.
    num_frames = 8'd1; ready_mode = 0; d0 = done_cnt; u0 = tuser_seen;
    send_frame(8, 4, 0, 16'(seed + 1), 2, -1);
    seed = 16'($urandom_range(0, 65535));
    send_frame(8, 4, 1, seed, -1, -1);
    vsync_close();
    drain();
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_tuser", tuser_seen - u0, 1);
    check("t2_errors", errs, 0);

    // Overflow: ready held low, only the first pixel is kept.
    num_frames = 8'd1; ready_mode = 1;
    pulse_start();
    seed = 16'($urandom_range(0, 65535));
    send_frame(8, 4, 2, seed, -1, -1);
    vsync_close();
    repeat (3) @(negedge xclk);
    check("t3_overflow", err_overflow, 1);
    check("t3_held_valid", axis_if.m_tvalid, 1);
    check("t3_held_data", axis_if.m_tdata, seed);
    check("t3_other_errors", {err_line_len, err_line_cnt, err_timeout}, 0);
    ready_mode = 2;
    drain();

    // Short lines (7 pixels) against an 8-pixel controller.
    num_frames = 8'd1; ready_mode = 0; d0 = done_cnt;
    pulse_start();
    seed = 16'($urandom_range(0, 65535));
    send_frame(7, 4, 1, seed, -1, 1);
    vsync_close();
    drain();
    check("t4_line_len", err_line_len, 1);
    check("t4_line_cnt", err_line_cnt, 0);
    check("t4_done_pulses", done_cnt - d0, 1);

    // Abort during ACTIVE with a pixel held in the output register.
    num_frames = 8'd2; ready_mode = 1; d0 = done_cnt;
    pulse_start();
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b1, 8'h00);
      tick(1'b0, 1'b1, 8'(c));
    end
    repeat (4) @(negedge xclk);
    check("t5_valid_before_abort", axis_if.m_tvalid, 1);
    check("t5_busy_before_abort", busy, 1);
    @(negedge xclk) abort = 1'b1;
    @(negedge xclk) abort = 1'b0;
    check("t5_after_abort", {axis_if.m_tvalid, cam_enable, busy}, 0);
    check("t5_sticky_kept", err_overflow, 1);
    ready_mode = 0;
    repeat (10) tick(1'b0, 1'b1, 8'h00);
    repeat (2) tick(1'b0, 1'b0, 8'h00);
    check("t5_no_done", done_cnt - d0, 0);
    num_frames = 8'd1;
    pulse_start();
    seed = 16'($urandom_range(0, 65535));
    send_frame(8, 4, 1, seed, -1, -1);
    vsync_close();
    drain();
    check("t5_restart_done", done_cnt - d0, 1);
    check("t5_restart_frames", frames_done, 1);
    check("t5_restart_errors", errs, 0);

    // VSYNC timeout on the second instance (VSYNC tied low, limit 100).
    @(negedge xclk) tmo_start = 1'b1;
    @(negedge xclk) tmo_start = 1'b0;
    check("tmo_enable_after_start", tmo_enable, 1);
    repeat (99) @(negedge xclk);
    check("tmo_not_yet_99", {tmo_err_timeout, tmo_busy}, 2'b01);
    @(negedge xclk);
    check("tmo_at_100", {tmo_err_timeout, tmo_enable, tmo_busy}, 3'b101);
    @(negedge xclk) tmo_start = 1'b1;
    @(negedge xclk) tmo_start = 1'b0;
    repeat (2) @(negedge xclk);
    check("tmo_start_ignored", {tmo_err_timeout, tmo_enable, tmo_busy}, 3'b101);
    @(negedge xclk) tmo_abort = 1'b1;
    @(negedge xclk) tmo_abort = 1'b0;
    check("tmo_abort_exit", {tmo_err_timeout, tmo_enable, tmo_busy}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
